mips32_fetch_queue: RTL

Instruction-fetch front end for the pipe_MIPS32 core. Generates word addresses into instruction memory over a req/ack handshake and buffers returned instructions with their next-PC in a small FIFO. The IF/ID stage pops them through a valid/ready handshake. Taken branches flush the queue and redirect the PC; a halt request stops new fetches.

---
 rtl/mips32_fetch_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: one-outstanding req/ack fetcher feeding a small {instr, npc} FIFO.
// Optional MIPS32_FQ_HLT_STOP_EN: a fetched HLT opcode stops further requests until flush or reset.
module mips32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk1,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_npc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     pc;
    logic            discard;
    logic            hlt_stop;

    logic            ack_live;
    logic            push;
    logic            pop;
    logic            issue;
    logic            hlt_hit;
    logic [AW-1:0]   rd_next;
    logic [CW-1:0]   count_next;
    entry_t          push_entry;
    entry_t          head_next;

    // A flush overrides both a push and a pop landing in the same cycle.
    always_comb begin
        ack_live   = imem_req && imem_ack;
        push       = ack_live && !discard && !branch_taken;
        pop        = out_valid && out_ready && !branch_taken;
        push_entry = '{instr: imem_rdata, npc: imem_addr + 32'd1};
        rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count + CW'(push) - CW'(pop);
        // The slot is implicitly reserved: only one request is in flight and it
        // issues only while count < DEPTH, so a push always finds room.
        issue      = !imem_req && !halt && (count < CW'(DEPTH)) && !branch_taken && !hlt_stop;
        // An empty-after-pop queue receiving a push presents the pushed word as head.
        head_next  = (push && (rd_next == wr_ptr)) ? push_entry : mem[rd_next];
    end

`ifdef MIPS32_FQ_HLT_STOP_EN
    always_comb hlt_hit = push && (imem_rdata[31:26] == 6'b111111);
`else
    always_comb hlt_hit = 1'b0;
`endif

    // NOTE: queue storage carries no reset; entries are only read once count says they were written.
    always_ff @(posedge clk1) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            pc        <= RESET_PC;
            discard   <= 1'b0;
            hlt_stop  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_npc   <= 32'd0;
        end else if (branch_taken) begin
            pc        <= branch_target;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            hlt_stop  <= 1'b0;
            if (ack_live) begin
                imem_req <= 1'b0;
                discard  <= 1'b0;
            end else if (imem_req) begin
                discard  <= 1'b1;
            end
        end else begin
            if (ack_live) begin
                imem_req <= 1'b0;
                discard  <= 1'b0;
                if (!discard) pc <= imem_addr + 32'd1;
            end else if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= pc;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (hlt_hit) hlt_stop <= 1'b1;
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            if (count_next != '0) begin
                out_instr <= head_next.instr;
                out_npc   <= head_next.npc;
            end
        end
    end

endmodule
